ddr_rd_stream_drain: RTL and testbench

//  Consumer stage directly downstream of the 256->32 bit asynchronous DDR read FIFO, in its read-clock domain.

---
 rtl/ddr_rd_stream_drain_if.sv | 37 +++
 rtl/ddr_rd_stream_drain.sv | 139 +++++++++++++
 tb/tb_ddr_rd_stream_drain.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_stream_drain_if.sv
// Bundle for the FIFO read port and the outgoing valid/ready stream of ddr_rd_stream_drain.
// master: the drain stage; slave: the FIFO plus downstream consumer.
interface ddr_rd_stream_drain_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEVEL_WIDTH = 12
);
    logic                   fifo_rd_en;
    logic [DATA_WIDTH-1:0]  fifo_rd_data;
    logic                   fifo_rd_empty;
    logic [LEVEL_WIDTH-1:0] fifo_rd_water_level;
    logic [DATA_WIDTH-1:0]  m_data;
    logic                   m_valid;
    logic                   m_last;
    logic                   m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        input  fifo_rd_water_level,
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_empty,
        output fifo_rd_water_level,
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/ddr_rd_stream_drain.sv
// Drains whole packets from the DDR read FIFO into a valid/ready stream with last marking.
// Optional `DDR_RD_DRAIN_UNDERRUN_EN adds a saturating underrun_cnt output.
module ddr_rd_stream_drain #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEVEL_WIDTH = 12,
    parameter int PKT_LEN     = 256,
    parameter int PKT_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    ddr_rd_stream_drain_if.master bus,
    output logic                  busy,
    output logic [PKT_CNT_W-1:0]  pkt_cnt
`ifdef DDR_RD_DRAIN_UNDERRUN_EN
    ,
    output logic [15:0]           underrun_cnt
`endif
);
    localparam int ISS_W = $clog2(PKT_LEN + 1);
    localparam logic [ISS_W-1:0]       ISS_MAX  = ISS_W'(PKT_LEN);
    localparam logic [ISS_W-1:0]       ISS_LAST = ISS_W'(PKT_LEN - 1);
    localparam logic [LEVEL_WIDTH-1:0] LVL_NEED = LEVEL_WIDTH'(PKT_LEN);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        WAIT_LAST
    } state_t;

    state_t              state;
    logic [ISS_W-1:0]    issued;
    logic                pending;
    logic                pending_last;

    logic [DATA_WIDTH:0] ob_mem [4];
    logic [1:0]          ob_wr;
    logic [1:0]          ob_rd;
    logic [2:0]          ob_cnt;

    logic room;
    logic can_issue;
    logic rd_en;
    logic push;
    logic pop;

    // Words already in the buffer plus the one still in the FIFO's read pipe
    // must leave a slot for the word being requested now.
    always_comb begin
        room      = (ob_cnt + {2'b00, pending}) <= 3'd2;
        can_issue = (state == BURST) && (issued < ISS_MAX) && room;
        rd_en     = can_issue && !bus.fifo_rd_empty;
        push      = pending;
        pop       = (ob_cnt != 3'd0) && bus.m_ready;
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (ob_cnt != 3'd0);
    assign bus.m_data     = ob_mem[ob_rd][DATA_WIDTH-1:0];
    assign bus.m_last     = ob_mem[ob_rd][DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_wr  <= '0;
            ob_rd  <= '0;
            ob_cnt <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                ob_mem[i[1:0]] <= '0;
            end
        end else begin
            if (push) begin
                ob_mem[ob_wr] <= {pending_last, bus.fifo_rd_data};
                ob_wr         <= ob_wr + 2'd1;
            end
            if (pop) begin
                ob_rd <= ob_rd + 2'd1;
            end
            case ({push, pop})
                2'b10:   ob_cnt <= ob_cnt + 3'd1;
                2'b01:   ob_cnt <= ob_cnt - 3'd1;
                default: ob_cnt <= ob_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            issued       <= '0;
            pending      <= 1'b0;
            pending_last <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            pending      <= rd_en;
            pending_last <= rd_en && (issued == ISS_LAST);
            case (state)
                IDLE: begin
                    if (enable && (bus.fifo_rd_water_level >= LVL_NEED)) begin
                        state  <= BURST;
                        busy   <= 1'b1;
                        issued <= '0;
                    end
                end
                BURST: begin
                    if (rd_en) begin
                        issued <= issued + ISS_W'(1);
                    end
                    if (issued == ISS_MAX) begin
                        state <= WAIT_LAST;
                    end
                end
                WAIT_LAST: begin
                    if (pop && bus.m_last) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DDR_RD_DRAIN_UNDERRUN_EN
    // Counts cycles where a read was wanted and allowed but the FIFO was empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (can_issue && bus.fifo_rd_empty && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_rd_stream_drain.sv
// Directed bench for ddr_rd_stream_drain: FIFO model, stream monitor, per-word sequence checks.
`timescale 1ns/1ps
module tb_ddr_rd_stream_drain;
    localparam int DW = 32;
    localparam int LW = 12;
    localparam int PL = 256;
    localparam int CW = 16;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic          busy;
    logic [CW-1:0] pkt_cnt;
`ifdef DDR_RD_DRAIN_UNDERRUN_EN
    logic [15:0]   underrun_cnt;
`endif

    ddr_rd_stream_drain_if #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW)) bus ();

    ddr_rd_stream_drain #(
        .DATA_WIDTH (DW),
        .LEVEL_WIDTH(LW),
        .PKT_LEN    (PL),
        .PKT_CNT_W  (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus),
        .busy   (busy),
        .pkt_cnt(pkt_cnt)
`ifdef DDR_RD_DRAIN_UNDERRUN_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // FIFO model: circular store, 1-cycle read latency, level = written - read
    logic [31:0] fmem [1024];
    int          rptr        = 0;
    int          wptr        = 0;
    logic        force_empty = 1'b0;
    logic        lvl_ovr_en  = 1'b0;
    logic [LW-1:0] lvl_ovr   = '0;

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rd_data <= fmem[rptr % 1024];
            rptr             <= rptr + 1;
        end
    end

    assign bus.fifo_rd_empty       = force_empty || (wptr == rptr);
    assign bus.fifo_rd_water_level = lvl_ovr_en ? lvl_ovr : LW'(wptr - rptr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor
    int   rden_cnt = 0, xfer_cnt = 0;
    int   first_rden_cyc = 0, last_rden_cyc = 0;
    int   first_xfer_cyc = 0, last_xfer_cyc = 0;
    int   exp_pos = 0, exp_i = 0;
    int   sync_gen = 0, sync_seen = 0, sync_pos = 0;
    logic hold_v = 1'b0;
    logic [31:0] hold_d = '0;
    logic hold_l = 1'b0;

    always @(negedge clk) begin : mon
        int pos;
        int idx;
        pos = exp_pos;
        idx = exp_i;
        if (sync_seen != sync_gen) begin
            pos = sync_pos;
            idx = 0;
        end
        sync_seen <= sync_gen;
        if (rst_n) begin
            if (bus.fifo_rd_en) begin
                if (rden_cnt == 0) first_rden_cyc <= cyc;
                last_rden_cyc <= cyc;
                rden_cnt      <= rden_cnt + 1;
            end
            if (hold_v) begin
                chk("hold_valid", 32'(bus.m_valid), 32'd1);
                chk("hold_data", bus.m_data, hold_d);
                chk("hold_last", 32'(bus.m_last), 32'(hold_l));
            end
            hold_v <= bus.m_valid && !bus.m_ready;
            hold_d <= bus.m_data;
            hold_l <= bus.m_last;
            if (bus.m_valid && bus.m_ready) begin
                chk("xfer_data", bus.m_data, fmem[pos % 1024]);
                chk("xfer_last", 32'(bus.m_last), 32'(idx == PL - 1));
                if (xfer_cnt == 0) first_xfer_cyc <= cyc;
                last_xfer_cyc <= cyc;
                xfer_cnt      <= xfer_cnt + 1;
                pos = pos + 1;
                idx = (idx == PL - 1) ? 0 : idx + 1;
            end
        end else begin
            hold_v <= 1'b0;
        end
        exp_pos <= pos;
        exp_i   <= idx;
    end

    logic [3:0] rdy_pat  = 4'b1001;
    logic       stall_en = 1'b0;
    int         ph       = 0;

    task automatic step();
        @(posedge clk);
        #1;
        bus.m_ready = stall_en ? rdy_pat[ph % 4] : 1'b1;
        ph++;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wptr % 1024] = 32'hA500_0000 + 32'(wptr);
            wptr++;
        end
    endtask

    task automatic wait_pkt(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while ((int'(pkt_cnt) != target) && (k < budget)) begin
            step();
            k++;
        end
        chk(tag, 32'(pkt_cnt), 32'(target));
    endtask

    initial begin
        int b;
        int bx;
        int k;
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_rden", 32'(bus.fifo_rd_en), 32'd0);
        chk("rst_data", bus.m_data, 32'd0);
        chk("rst_last", 32'(bus.m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt", 32'(pkt_cnt), 32'd0);
`ifdef DDR_RD_DRAIN_UNDERRUN_EN
        chk("rst_underrun", 32'(underrun_cnt), 32'd0);
`endif
        step();
        rst_n = 1'b1;

        // 1: back-to-back packet
        load(PL);
        enable = 1'b1;
        wait_pkt("t1_pkt", 1, 400);
        repeat (3) step();
        @(negedge clk);
        chk("t1_rden_n", 32'(rden_cnt), 32'd256);
        chk("t1_rden_span", 32'(last_rden_cyc - first_rden_cyc), 32'd255);
        chk("t1_xfer_n", 32'(xfer_cnt), 32'd256);
        chk("t1_xfer_span", 32'(last_xfer_cyc - first_xfer_cyc), 32'd255);
        chk("t1_latency", 32'(first_xfer_cyc - first_rden_cyc), 32'd2);
        chk("t1_busy", 32'(busy), 32'd0);

        // 2: level threshold
        step();
        lvl_ovr    = LW'(255);
        lvl_ovr_en = 1'b1;
        load(PL);
        step();
        b = rden_cnt;
        repeat (20) step();
        @(negedge clk);
        chk("t2_idle_busy", 32'(busy), 32'd0);
        chk("t2_idle_rden_n", 32'(rden_cnt - b), 32'd0);
        chk("t2_idle_rden", 32'(bus.fifo_rd_en), 32'd0);
        step();
        lvl_ovr = LW'(256);
        @(negedge clk);
        chk("t2_busy_pre", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t2_busy_post", 32'(busy), 32'd1);
        step();
        lvl_ovr_en = 1'b0;
        wait_pkt("t2_pkt", 2, 400);

        // 3: ready pattern 1,0,0,1
        bx = xfer_cnt;
        stall_en = 1'b1;
        ph = 0;
        load(PL);
        step();
        wait_pkt("t3_pkt", 3, 1500);
        stall_en = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("t3_words", 32'(xfer_cnt - bx), 32'd256);

        // 4: enable dropped mid-packet
        step();
        b  = rden_cnt;
        bx = xfer_cnt;
        load(2 * PL);
        k = 0;
        while ((rden_cnt - b < 101) && (k < 400)) begin
            step();
            k++;
        end
        chk("t4_reach101", 32'(rden_cnt - b >= 101), 32'd1);
        enable = 1'b0;
        wait_pkt("t4_pkt", 4, 600);
        repeat (10) step();
        @(negedge clk);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_rden_n", 32'(rden_cnt - b), 32'd256);
        chk("t4_words", 32'(xfer_cnt - bx), 32'd256);
        chk("t4_level", 32'(bus.fifo_rd_water_level), 32'd256);
        chk("t4_rden", 32'(bus.fifo_rd_en), 32'd0);

        // 5: reset mid-packet
        step();
        bx = xfer_cnt;
        enable = 1'b1;
        k = 0;
        while ((xfer_cnt - bx < 50) && (k < 400)) begin
            step();
            k++;
        end
        chk("t5_reach50", 32'(xfer_cnt - bx >= 50), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(bus.m_valid), 32'd0);
        chk("t5_rst_rden", 32'(bus.fifo_rd_en), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_pkt", 32'(pkt_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        sync_pos = rptr;
        sync_gen = sync_gen + 1;
        rst_n = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_rden", 32'(bus.fifo_rd_en), 32'd0);
        step();
        b = rden_cnt;
        load(PL);
        wait_pkt("t5_pkt", 1, 400);
        repeat (3) step();
        @(negedge clk);
        chk("t5_rden_n", 32'(rden_cnt - b), 32'd256);

        // 6: FIFO empty for 3 burst cycles
        step();
        b = rden_cnt;
        load(PL);
        k = 0;
        while ((rden_cnt - b < 20) && (k < 400)) begin
            step();
            k++;
        end
        chk("t6_reach20", 32'(rden_cnt - b >= 20), 32'd1);
        force_empty = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_rden", 32'(bus.fifo_rd_en), 32'd0);
            chk("t6_busy", 32'(busy), 32'd1);
            @(posedge clk);
        end
        #1;
        force_empty = 1'b0;
`ifdef DDR_RD_DRAIN_UNDERRUN_EN
        chk("t6_underrun", 32'(underrun_cnt), 32'd3);
`endif
        wait_pkt("t6_pkt", 2, 400);
        repeat (3) step();
        @(negedge clk);
        chk("t6_rden_n", 32'(rden_cnt - b), 32'd256);
`ifdef DDR_RD_DRAIN_UNDERRUN_EN
        chk("t6_underrun_end", 32'(underrun_cnt), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
